// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its central sequencer.
// The datapath side (master) reports hazard status and receives register enables and flushes.
interface pipe_hazard_if;
    logic [3:0]  ifid_Opcode;
    logic [3:0]  ifid_RegRs;
    logic [3:0]  ifid_RegRt;
    logic        ifid_use_rs;
    logic        ifid_use_rt;
    logic        idex_MemRead;
    logic [3:0]  idex_RegRd;
    logic        branch_taken;
    logic        exmem_mem_access;
    logic        dmem_ready;

    logic        pc_wen;
    logic        ifid_wen;
    logic        ifid_flush;
    logic        idex_wen;
    logic        idex_flush;
    logic        exmem_wen;
    logic        memwb_wen;
    logic        halted;
    logic        mem_err;
    logic [15:0] stall_cycles;

    modport master (
        output ifid_Opcode, ifid_RegRs, ifid_RegRt, ifid_use_rs, ifid_use_rt,
               idex_MemRead, idex_RegRd, branch_taken, exmem_mem_access, dmem_ready,
        input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_wen,
               halted, mem_err, stall_cycles
    );

    modport slave (
        input  ifid_Opcode, ifid_RegRs, ifid_RegRt, ifid_use_rs, ifid_use_rt,
               idex_MemRead, idex_RegRd, branch_taken, exmem_mem_access, dmem_ready,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_wen,
               halted, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer: load-use interlock, branch squash, data-memory wait with timeout,
// and HLT drain-to-halt. Enables/flushes are combinational from registered state and inputs.
module pipe_hazard_ctrl #(
    parameter logic [3:0]  HLT_OPCODE   = 4'hF,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave hz
);
    localparam int DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

    state_t         state, stateNext;
    logic           resumeDrain, resumeDrainNext;
    logic [DCW-1:0] drainCnt, drainCntNext;
    logic [WCW-1:0] waitCnt, waitCntNext;
    logic [15:0]    stallCycles;
    logic           halted, mem_err;
    logic           haltSet, errSet;
    logic           lu, memhold;

    assign lu = hz.idex_MemRead && (hz.idex_RegRd != 4'd0) &&
                ((hz.ifid_use_rs && (hz.ifid_RegRs == hz.idex_RegRd)) ||
                 (hz.ifid_use_rt && (hz.ifid_RegRt == hz.idex_RegRd)));
    assign memhold = hz.exmem_mem_access && !hz.dmem_ready;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        hz.pc_wen       = 1'b1;
        hz.ifid_wen     = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_wen     = 1'b1;
        hz.idex_flush   = 1'b0;
        hz.exmem_wen    = 1'b1;
        hz.memwb_wen    = 1'b1;
        stateNext       = state;
        resumeDrainNext = resumeDrain;
        drainCntNext    = drainCnt;
        waitCntNext     = waitCnt;
        haltSet         = 1'b0;
        errSet          = 1'b0;

        if (!rst) begin
            {hz.pc_wen, hz.ifid_wen, hz.idex_wen, hz.exmem_wen, hz.memwb_wen} = 5'b0;
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (memhold) begin
                        {hz.pc_wen, hz.ifid_wen, hz.idex_wen, hz.exmem_wen, hz.memwb_wen} = 5'b0;
                        waitCntNext     = WCW'(1);
                        resumeDrainNext = (state == DRAIN);
                        stateNext       = MEMWAIT;
                    end else if (state == DRAIN) begin
                        // IF/ID holds only nops while draining, so load-use is irrelevant here.
                        hz.pc_wen     = 1'b0;
                        hz.ifid_flush = 1'b1;
                        if (drainCnt == '0) begin
                            haltSet   = 1'b1;
                            stateNext = HALTED;
                        end else begin
                            drainCntNext = drainCnt - 1'b1;
                        end
                    end else if (lu) begin
                        hz.pc_wen     = 1'b0;
                        hz.ifid_wen   = 1'b0;
                        hz.idex_flush = 1'b1;
                    end else if (hz.branch_taken) begin
                        hz.ifid_flush = 1'b1;
                    end else if (hz.ifid_Opcode == HLT_OPCODE) begin
                        hz.pc_wen     = 1'b0;
                        hz.ifid_flush = 1'b1;
                        drainCntNext  = DCW'(DRAIN_CYCLES - 1);
                        stateNext     = DRAIN;
                    end
                end
                MEMWAIT: begin
                    if (hz.dmem_ready) begin
                        waitCntNext = '0;
                        stateNext   = resumeDrain ? DRAIN : RUN;
                    end else begin
                        {hz.pc_wen, hz.ifid_wen, hz.idex_wen, hz.exmem_wen, hz.memwb_wen} = 5'b0;
                        if (waitCnt == WCW'(MEM_TIMEOUT)) begin
                            errSet    = 1'b1;
                            haltSet   = 1'b1;
                            stateNext = HALTED;
                        end else begin
                            waitCntNext = waitCnt + 1'b1;
                        end
                    end
                end
                default: begin
                    {hz.pc_wen, hz.ifid_wen, hz.idex_wen, hz.exmem_wen, hz.memwb_wen} = 5'b0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            resumeDrain <= 1'b0;
            drainCnt    <= '0;
            waitCnt     <= '0;
            stallCycles <= '0;
            halted      <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            state       <= stateNext;
            resumeDrain <= resumeDrainNext;
            drainCnt    <= drainCntNext;
            waitCnt     <= waitCntNext;
            if (haltSet) halted  <= 1'b1;
            if (errSet)  mem_err <= 1'b1;
            if (!hz.pc_wen && (state == RUN || state == MEMWAIT) && stallCycles != 16'hFFFF)
                stallCycles <= stallCycles + 16'd1;
        end
    end

    assign hz.halted       = halted;
    assign hz.mem_err      = mem_err;
    assign hz.stall_cycles = stallCycles;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, memory wait, timeout, priority and halt drain.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   nCompared = 0;
    int   nMismatched = 0;

    pipe_hazard_if hz();

    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    // Control vector order: pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_wen
    localparam logic [6:0] C_RESET  = 7'b0010100;
    localparam logic [6:0] C_NORMAL = 7'b1101011;
    localparam logic [6:0] C_FROZEN = 7'b0000000;
    localparam logic [6:0] C_LU     = 7'b0001111;
    localparam logic [6:0] C_BRANCH = 7'b1111011;
    localparam logic [6:0] C_DRAIN  = 7'b0111011;

    function automatic logic [6:0] ctl();
        return {hz.pc_wen, hz.ifid_wen, hz.ifid_flush, hz.idex_wen, hz.idex_flush,
                hz.exmem_wen, hz.memwb_wen};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hz.ifid_Opcode      = 4'h0;
        hz.ifid_RegRs       = 4'h0;
        hz.ifid_RegRt       = 4'h0;
        hz.ifid_use_rs      = 1'b0;
        hz.ifid_use_rt      = 1'b0;
        hz.idex_MemRead     = 1'b0;
        hz.idex_RegRd       = 4'h0;
        hz.branch_taken     = 1'b0;
        hz.exmem_mem_access = 1'b0;
        hz.dmem_ready       = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        #1;
        nCompared++;
        if (ctl() !== C_RESET) begin
            nMismatched++;
            $display("FAIL reset_ctl_early: got %b expected %b", ctl(), C_RESET);
        end
        tick();
        tick();
        nCompared++;
        if (ctl() !== C_RESET || hz.halted !== 1'b0 || hz.mem_err !== 1'b0 || hz.stall_cycles !== 16'd0) begin
            nMismatched++;
            $display("FAIL reset_state: ctl=%b halted=%b err=%b stall=%0d expected ctl=%b 0 0 0",
                     ctl(), hz.halted, hz.mem_err, hz.stall_cycles, C_RESET);
        end
        rst = 1'b1;
        #1;
        nCompared++;
        if (ctl() !== C_NORMAL) begin
            nMismatched++;
            $display("FAIL reset_release: got %b expected %b", ctl(), C_NORMAL);
        end
        tick();
        nCompared++;
        if (ctl() !== C_NORMAL || hz.stall_cycles !== 16'd0) begin
            nMismatched++;
            $display("FAIL run_idle: ctl=%b stall=%0d expected %b 0", ctl(), hz.stall_cycles, C_NORMAL);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        hz.idex_MemRead = 1'b1;
        hz.idex_RegRd   = 4'd3;
        hz.ifid_RegRs   = 4'd3;
        hz.ifid_use_rs  = 1'b1;
        #1;
        nCompared++;
        if (ctl() !== C_LU) begin
            nMismatched++;
            $display("FAIL lu_rs: got %b expected %b", ctl(), C_LU);
        end
        tick();
        set_idle();
        #1;
        nCompared++;
        if (hz.stall_cycles !== 16'd1 || ctl() !== C_NORMAL) begin
            nMismatched++;
            $display("FAIL lu_one_bubble: stall=%0d ctl=%b expected 1 %b", hz.stall_cycles, ctl(), C_NORMAL);
        end
        // Destination r0 never creates a dependency.
        hz.idex_MemRead = 1'b1;
        hz.idex_RegRd   = 4'd0;
        hz.ifid_RegRs   = 4'd0;
        hz.ifid_use_rs  = 1'b1;
        #1;
        nCompared++;
        if (ctl() !== C_NORMAL) begin
            nMismatched++;
            $display("FAIL lu_r0: got %b expected %b", ctl(), C_NORMAL);
        end
        tick();
        set_idle();
        hz.idex_MemRead = 1'b1;
        hz.idex_RegRd   = 4'd5;
        hz.ifid_RegRt   = 4'd5;
        hz.ifid_use_rt  = 1'b1;
        #1;
        nCompared++;
        if (ctl() !== C_LU) begin
            nMismatched++;
            $display("FAIL lu_rt: got %b expected %b", ctl(), C_LU);
        end
        hz.ifid_use_rt = 1'b0;
        #1;
        nCompared++;
        if (ctl() !== C_NORMAL) begin
            nMismatched++;
            $display("FAIL lu_rt_unused: got %b expected %b", ctl(), C_NORMAL);
        end
        tick();
        set_idle();
        #1;
        nCompared++;
        if (hz.stall_cycles !== 16'd1) begin
            nMismatched++;
            $display("FAIL lu_no_extra_stall: got %0d expected 1", hz.stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        hz.exmem_mem_access = 1'b1;
        hz.dmem_ready       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            nCompared++;
            if (ctl() !== C_FROZEN) begin
                nMismatched++;
                $display("FAIL memwait_frozen[%0d]: got %b expected %b", i, ctl(), C_FROZEN);
            end
            tick();
        end
        hz.dmem_ready = 1'b1;
        #1;
        nCompared++;
        if (ctl() !== C_NORMAL) begin
            nMismatched++;
            $display("FAIL memwait_release: got %b expected %b", ctl(), C_NORMAL);
        end
        tick();
        set_idle();
        #1;
        nCompared++;
        if (hz.stall_cycles !== 16'd3 || ctl() !== C_NORMAL || hz.mem_err !== 1'b0) begin
            nMismatched++;
            $display("FAIL memwait_after: stall=%0d ctl=%b err=%b expected 3 %b 0",
                     hz.stall_cycles, ctl(), hz.mem_err, C_NORMAL);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        hz.exmem_mem_access = 1'b1;
        hz.dmem_ready       = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        nCompared++;
        if (hz.mem_err !== 1'b0 || hz.halted !== 1'b0) begin
            nMismatched++;
            $display("FAIL timeout_early: err=%b halted=%b expected 0 0", hz.mem_err, hz.halted);
        end
        tick();
        nCompared++;
        if (hz.mem_err !== 1'b1 || hz.halted !== 1'b1 || hz.stall_cycles !== 16'd256) begin
            nMismatched++;
            $display("FAIL timeout_hit: err=%b halted=%b stall=%0d expected 1 1 256",
                     hz.mem_err, hz.halted, hz.stall_cycles);
        end
        set_idle();
        tick();
        tick();
        #1;
        nCompared++;
        if (ctl() !== C_FROZEN || hz.mem_err !== 1'b1 || hz.halted !== 1'b1) begin
            nMismatched++;
            $display("FAIL timeout_sticky: ctl=%b err=%b halted=%b expected %b 1 1",
                     ctl(), hz.mem_err, hz.halted, C_FROZEN);
        end
        rst = 1'b0;
        #1;
        nCompared++;
        if (ctl() !== C_RESET) begin
            nMismatched++;
            $display("FAIL timeout_rst_ctl: got %b expected %b", ctl(), C_RESET);
        end
        tick();
        nCompared++;
        if (hz.mem_err !== 1'b0 || hz.halted !== 1'b0) begin
            nMismatched++;
            $display("FAIL timeout_rst_clear: err=%b halted=%b expected 0 0", hz.mem_err, hz.halted);
        end
        rst = 1'b1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        hz.idex_MemRead = 1'b1;
        hz.idex_RegRd   = 4'd7;
        hz.ifid_RegRs   = 4'd7;
        hz.ifid_use_rs  = 1'b1;
        hz.branch_taken = 1'b1;
        #1;
        nCompared++;
        if (ctl() !== C_LU) begin
            nMismatched++;
            $display("FAIL lu_over_branch: got %b expected %b", ctl(), C_LU);
        end
        tick();
        hz.idex_MemRead = 1'b0;
        #1;
        nCompared++;
        if (ctl() !== C_BRANCH) begin
            nMismatched++;
            $display("FAIL branch_after_lu: got %b expected %b", ctl(), C_BRANCH);
        end
        tick();
        set_idle();
    endtask

    task automatic test_halt();
        do_reset();
        hz.ifid_Opcode = 4'hF;
        #1;
        nCompared++;
        if (ctl() !== C_DRAIN) begin
            nMismatched++;
            $display("FAIL hlt_detect: got %b expected %b", ctl(), C_DRAIN);
        end
        tick();
        hz.ifid_Opcode = 4'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            nCompared++;
            if (ctl() !== C_DRAIN || hz.halted !== 1'b0) begin
                nMismatched++;
                $display("FAIL drain[%0d]: ctl=%b halted=%b expected %b 0", i, ctl(), hz.halted, C_DRAIN);
            end
            tick();
        end
        nCompared++;
        if (hz.halted !== 1'b1 || ctl() !== C_FROZEN || hz.stall_cycles !== 16'd1) begin
            nMismatched++;
            $display("FAIL halted: halted=%b ctl=%b stall=%0d expected 1 %b 1",
                     hz.halted, ctl(), hz.stall_cycles, C_FROZEN);
        end

        // Two-cycle memory access mid-drain: one not-ready cycle, then the ready cycle.
        do_reset();
        hz.ifid_Opcode = 4'hF;
        tick();
        hz.ifid_Opcode = 4'h0;
        tick();
        tick();
        hz.exmem_mem_access = 1'b1;
        hz.dmem_ready       = 1'b0;
        #1;
        nCompared++;
        if (ctl() !== C_FROZEN) begin
            nMismatched++;
            $display("FAIL drain_memhold: got %b expected %b", ctl(), C_FROZEN);
        end
        tick();
        hz.dmem_ready = 1'b1;
        tick();
        set_idle();
        tick();
        nCompared++;
        if (hz.halted !== 1'b0) begin
            nMismatched++;
            $display("FAIL drain_delay_early: halted=%b expected 0", hz.halted);
        end
        tick();
        nCompared++;
        if (hz.halted !== 1'b1) begin
            nMismatched++;
            $display("FAIL drain_delay_late: halted=%b expected 1", hz.halted);
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_simultaneous();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage 16-bit pipeline.
- Drives the write-enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Covers four cases: load-use interlock, taken-branch squash, variable-latency data-memory wait (with timeout) and HLT drain-to-halt.
- Control outputs are combinational from registered state plus current inputs; the flush outputs are ORed by the top level into each pipeline register's reset.

Parameters:
HLT_OPCODE, 4'hF, opcode that starts drain
DRAIN_CYCLES, 4, cycles after HLT leaves ID before freeze
MEM_TIMEOUT, 255, max wait cycles on data memory before error

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low
ifid_Opcode  in  4  opcode in IF/ID
ifid_RegRs  in  4  source reg 1 in IF/ID
ifid_RegRt  in  4  source reg 2 in IF/ID
ifid_use_rs  in  1  ID instr reads Rs
ifid_use_rt  in  1  ID instr reads Rt
idex_MemRead  in  1  EX instr is a load
idex_RegRd  in  4  EX instr destination
branch_taken  in  1  ID resolved a taken branch/jump
exmem_mem_access  in  1  MEM instr accesses data memory
dmem_ready  in  1  data memory completes this cycle
pc_wen  out  1  PC write enable
ifid_wen  out  1  IF/ID enable
ifid_flush  out  1  clear IF/ID (nop)
idex_wen  out  1  ID/EX enable
idex_flush  out  1  clear ID/EX (bubble)
exmem_wen  out  1  EX/MEM enable
memwb_wen  out  1  MEM/WB enable
halted  out  1  pipeline frozen after HLT
mem_err  out  1  data-memory timeout, sticky
stall_cycles  out  16  saturating count of frozen-PC cycles in RUN/MEMWAIT

Behaviour:
- rst low at a clock edge: state<=RUN, drain_cnt<=0, wait_cnt<=0, stall_cycles<=0, halted<=0, mem_err<=0.
- While rst is low: all wen=0 and all flushes (ifid_flush, idex_flush) =1.
- States: RUN, MEMWAIT, DRAIN, HALTED.
- lu (load-use) = idex_MemRead & idex_RegRd!=0 & ((ifid_use_rs & ifid_RegRs==idex_RegRd) | (ifid_use_rt & ifid_RegRt==idex_RegRd)).
- memhold = exmem_mem_access & !dmem_ready.
- Default outputs: all wen=1, flushes=0.
- Priority within RUN/DRAIN: memhold > lu > branch_taken > HLT detect.
- memhold: all five wen=0, no flush, wait_cnt<=1, next=MEMWAIT. Resume state is saved: RUN or DRAIN.
- lu (no memhold): pc_wen=0, ifid_wen=0, idex_flush=1; EX/MEM and MEM/WB advance. Exactly one bubble per load.
- branch_taken (no memhold, no lu): ifid_flush=1; PC loads target.
- RUN with ifid_Opcode==HLT_OPCODE and none of the above: pc_wen=0, ifid_flush=1, drain_cnt<=DRAIN_CYCLES-1, next=DRAIN.
- MEMWAIT:
  - All wen=0 while !dmem_ready; wait_cnt increments each cycle.
  - Cycle with dmem_ready=1: all wen=1, wait_cnt<=0, return to saved state. No hazard is evaluated that cycle; the IF/ID contents were frozen, so lu re-evaluates next cycle.
  - wait_cnt==MEM_TIMEOUT with !dmem_ready: mem_err<=1, halted<=1, next=HALTED.
- DRAIN:
  - pc_wen=0, ifid_flush=1 every cycle.
  - lu is ignored, since IF/ID holds only nops.
  - memhold pauses the drain via MEMWAIT; drain_cnt is not decremented.
  - Otherwise drain_cnt decrements. At drain_cnt==0: halted<=1, next=HALTED.
- HALTED: all wen=0, flushes=0; exited only by rst low.
- stall_cycles increments when pc_wen=0 in RUN or MEMWAIT; it saturates at 16'hFFFF.
- Outputs carry no added latency: a hazard seen in cycle N gates the cycle N edge.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> all wen=0, both flushes=1, halted=0, stall_cycles=0. After release: all wen=1, state RUN.
- Load-use: idex_MemRead=1, idex_RegRd=3, ifid_RegRs=3, ifid_use_rs=1 for 1 cycle -> pc_wen=ifid_wen=0, idex_flush=1, exmem_wen=memwb_wen=1, stall_cycles=1. Same case with idex_RegRd=0 -> no stall.
- Memory wait: exmem_mem_access=1, dmem_ready=0 for 3 cycles, then 1 -> all wen=0 for 3 cycles, all wen=1 on the 4th, stall_cycles=3.
- Timeout: dmem_ready held 0 for 256 cycles -> mem_err=1, halted=1; wen stay 0 until rst low.
- Simultaneous events: branch_taken=1 with lu=1 -> lu wins (idex_flush=1, ifid_flush=0). Branch is applied next cycle once lu clears.
- Halt: ifid_Opcode=4'hF -> pc_wen=0, ifid_flush=1 for 4 cycles, then halted=1. A memhold of 2 cycles injected mid-drain delays halted by exactly 2 cycles.
